// File: rtl/audio_led_sched_pkg.sv
// Shared types and constants for the audio level LED scheduler.
package audio_led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_CPU  = 2'd1,
    ST_WR_AUTO = 2'd2
  } state_e;

  localparam logic [1:0] CSR_CTRL       = 2'd0;
  localparam logic [1:0] CSR_MANUAL_PAT = 2'd1;
  localparam logic [1:0] CSR_STATUS     = 2'd2;
  localparam logic [1:0] CSR_RSVD       = 2'd3;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_MANUAL_BIT = 1;

  localparam int unsigned LED_W = 8;
  localparam int unsigned LVL_W = 16;
  localparam int unsigned BAR_W = 4;

  // Lowest n bits set, n in 0..8
  function automatic logic [7:0] thermo8(input logic [3:0] n);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      t[i] = (4'(i) < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/audio_led_meter.sv
// Level meter: windowed peak accumulator, bar height and decaying peak marker.
module audio_led_meter
  import audio_led_sched_pkg::*;
#(
  parameter int unsigned PEAK_DECAY_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             lvl_valid,
  input  logic [LVL_W-1:0] lvl_data,
  output logic [LED_W-1:0] auto_pat_c,
  output logic             auto_valid_c
);

  logic [LVL_W-1:0] acc;
  logic [BAR_W-1:0] peak;
  logic [7:0]       decay_cnt;

  logic [BAR_W-1:0] bar_c;
  logic [BAR_W-1:0] peak_nxt_c;
  logic [7:0]       decay_nxt_c;
  logic [8:0]       decay_inc_c;
  logic [LED_W-1:0] marker_c;

  // Values the meter takes on at the next tick; the pattern reflects the updated peak
  always_comb begin
    bar_c       = (acc == '0) ? '0 : BAR_W'(acc[15:13]) + BAR_W'(1);
    decay_inc_c = 9'(decay_cnt) + 9'd1;
    peak_nxt_c  = peak;
    decay_nxt_c = decay_cnt;
    if (bar_c > peak) begin
      peak_nxt_c  = bar_c;
      decay_nxt_c = '0;
    end else if (decay_inc_c == 9'(PEAK_DECAY_TICKS)) begin
      decay_nxt_c = '0;
      if (peak != '0) begin
        peak_nxt_c = peak - BAR_W'(1);
      end
    end else begin
      decay_nxt_c = decay_inc_c[7:0];
    end
    marker_c     = (peak_nxt_c == '0) ? '0 : LED_W'(1) << (peak_nxt_c - BAR_W'(1));
    auto_pat_c   = thermo8(bar_c) | marker_c;
    auto_valid_c = tick;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      peak      <= '0;
      decay_cnt <= '0;
    end else if (tick) begin
      acc       <= lvl_valid ? lvl_data : '0;
      peak      <= peak_nxt_c;
      decay_cnt <= decay_nxt_c;
    end else if (lvl_valid && (lvl_data > acc)) begin
      acc <= lvl_data;
    end
  end

endmodule

// File: rtl/audio_led_sched.sv
// Schedules LED PIO writes from CPU requests and periodic audio meter updates.
module audio_led_sched
  import audio_led_sched_pkg::*;
#(
  parameter int unsigned UPDATE_CYCLES    = 500000,
  parameter int unsigned PEAK_DECAY_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic        lvl_valid,
  input  logic [15:0] lvl_data,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  localparam int unsigned CNT_W = $clog2(UPDATE_CYCLES);

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ctrl_en, ctrl_manual;
  logic [LED_W-1:0] manual_pat, auto_pat_q, last_written, led_q;
  logic             cpu_pending, auto_pending;

  logic             csr_wr_c, tick_c, cpu_set_c, cpu_clr_c, auto_clr_c, busy_c;
  logic             cs_nxt;
  logic [LED_W-1:0] wd_nxt;
  logic [LED_W-1:0] auto_pat_c;
  logic             auto_valid_c;
  logic             wdata_unused;

  assign csr_wr_c     = s_chipselect && !s_write_n;
  assign tick_c       = ctrl_en && (cnt == CNT_W'(UPDATE_CYCLES - 1));
  assign busy_c       = (state_q != ST_IDLE);
  assign cpu_set_c    = csr_wr_c && ((s_address == CSR_MANUAL_PAT) ||
                        ((s_address == CSR_CTRL) && s_writedata[CTRL_MANUAL_BIT] && !ctrl_manual));
  assign m_address    = 2'b00;
  assign m_writedata  = {24'b0, led_q};
  assign wdata_unused = ^s_writedata[31:8];

  audio_led_meter #(
    .PEAK_DECAY_TICKS(PEAK_DECAY_TICKS)
  ) u_meter (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick_c),
    .lvl_valid    (lvl_valid),
    .lvl_data     (lvl_data),
    .auto_pat_c   (auto_pat_c),
    .auto_valid_c (auto_valid_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!ctrl_en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // CSR registers and request flags; a new request wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en      <= 1'b0;
      ctrl_manual  <= 1'b0;
      manual_pat   <= '0;
      cpu_pending  <= 1'b0;
      auto_pending <= 1'b0;
      auto_pat_q   <= '0;
      last_written <= '0;
    end else begin
      if (csr_wr_c && (s_address == CSR_CTRL)) begin
        ctrl_en     <= s_writedata[CTRL_EN_BIT];
        ctrl_manual <= s_writedata[CTRL_MANUAL_BIT];
      end
      if (csr_wr_c && (s_address == CSR_MANUAL_PAT)) begin
        manual_pat <= s_writedata[7:0];
      end
      if (cpu_set_c) begin
        cpu_pending <= 1'b1;
      end else if (cpu_clr_c) begin
        cpu_pending <= 1'b0;
      end
      if (auto_valid_c) begin
        auto_pending <= 1'b1;
        auto_pat_q   <= auto_pat_c;
      end else if (auto_clr_c) begin
        auto_pending <= 1'b0;
      end
      if (state_q != ST_IDLE) begin
        last_written <= led_q;
      end
    end
  end

  // State and bus output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      led_q        <= '0;
    end else begin
      state_q      <= state_nxt;
      m_chipselect <= cs_nxt;
      m_write_n    <= !cs_nxt;
      led_q        <= wd_nxt;
    end
  end

  // Next state: CPU writes take priority; unchanged auto patterns are dropped
  always_comb begin
    state_nxt  = state_q;
    cpu_clr_c  = 1'b0;
    auto_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_pending && ctrl_manual) begin
          state_nxt = ST_WR_CPU;
          cpu_clr_c = 1'b1;
        end else if (auto_pending && !ctrl_manual && ctrl_en) begin
          auto_clr_c = 1'b1;
          if (auto_pat_q != last_written) begin
            state_nxt = ST_WR_AUTO;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_nxt = 1'b0;
    wd_nxt = '0;
    case (state_nxt)
      ST_WR_CPU: begin
        cs_nxt = 1'b1;
        wd_nxt = manual_pat;
      end
      ST_WR_AUTO: begin
        cs_nxt = 1'b1;
        wd_nxt = auto_pat_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      CSR_CTRL:       s_readdata = {30'b0, ctrl_manual, ctrl_en};
      CSR_MANUAL_PAT: s_readdata = {24'b0, manual_pat};
      CSR_STATUS:     s_readdata = {16'b0, last_written, 7'b0, busy_c};
      CSR_RSVD:       s_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_audio_led_sched.sv
// Directed bench for audio_led_sched with a per-cycle reference model and literal write logs.
module tb_audio_led_sched;

  localparam int UPD = 4;
  localparam int DEC = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_address = 2'd2;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        lvl_valid = 1'b0;
  logic [15:0] lvl_data = '0;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  int checks = 0;
  int errors = 0;
  int wlog[$];
  int stlog[$];
  int exp_q[$];

  int md_cnt = 0, md_acc = 0, md_peak = 0, md_dc = 0, md_pat = 0;
  int md_auto_val = 0, md_last = 0, md_wd = 0;
  bit md_en = 0, md_man = 0, md_cpu_p = 0, md_auto_p = 0, md_wr = 0;

  audio_led_sched #(
    .UPDATE_CYCLES   (UPD),
    .PEAK_DECAY_TICKS(DEC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .lvl_valid    (lvl_valid),
    .lvl_data     (lvl_data),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_cnt = 0; md_acc = 0; md_peak = 0; md_dc = 0; md_pat = 0;
    md_auto_val = 0; md_last = 0; md_wd = 0;
    md_en = 0; md_man = 0; md_cpu_p = 0; md_auto_p = 0; md_wr = 0;
  endtask

  // One clock of the scheduler described by its rules: bus decision, meter tick, CSR writes
  task automatic model_step();
    bit tick, wr, n_wr, n_cpu, n_auto;
    int n_wd, n_last, bar;
    wr     = s_chipselect && !s_write_n;
    tick   = md_en && (md_cnt == UPD - 1);
    n_wr   = 0;
    n_wd   = 0;
    n_last = md_last;
    n_cpu  = md_cpu_p;
    n_auto = md_auto_p;
    if (md_wr) n_last = md_wd;
    else if (md_cpu_p && md_man) begin
      n_wr = 1; n_wd = md_pat; n_cpu = 0;
    end else if (md_auto_p && !md_man && md_en) begin
      n_auto = 0;
      if (md_auto_val != md_last) begin
        n_wr = 1; n_wd = md_auto_val;
      end
    end
    if (tick) begin
      bar = (md_acc == 0) ? 0 : (md_acc / 8192) + 1;
      if (bar > md_peak) begin
        md_peak = bar; md_dc = 0;
      end else begin
        md_dc++;
        if (md_dc == DEC) begin
          md_dc = 0;
          if (md_peak > 0) md_peak--;
        end
      end
      md_auto_val = ((1 << bar) - 1) | ((md_peak > 0) ? (1 << (md_peak - 1)) : 0);
      n_auto = 1;
      md_acc = lvl_valid ? int'(lvl_data) : 0;
    end else if (lvl_valid && int'(lvl_data) > md_acc) begin
      md_acc = int'(lvl_data);
    end
    md_cnt = (md_en && !tick) ? md_cnt + 1 : 0;
    if (wr && s_address == 2'd0) begin
      if (s_writedata[1] && !md_man) n_cpu = 1;
      md_en  = s_writedata[0];
      md_man = s_writedata[1];
    end
    if (wr && s_address == 2'd1) begin
      md_pat = int'(s_writedata[7:0]);
      n_cpu  = 1;
    end
    md_wr = n_wr; md_wd = n_wd; md_last = n_last; md_cpu_p = n_cpu; md_auto_p = n_auto;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, md_man, md_en};
      2'd1:    return 32'(md_pat);
      2'd2:    return {16'b0, 8'(md_last), 7'b0, md_wr};
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    #1;
    chk("m_chipselect", 32'(m_chipselect), 32'(md_wr));
    chk("m_write_n", 32'(m_write_n), 32'(!md_wr));
    chk("m_writedata", m_writedata, md_wr ? 32'(md_wd) : 32'h0);
    chk("m_address", 32'(m_address), 32'h0);
    chk("s_readdata", s_readdata, exp_rd(s_address));
    if (m_chipselect && !m_write_n) begin
      wlog.push_back(int'(m_writedata[7:0]));
      if (s_address == 2'd2) stlog.push_back(int'(s_readdata));
    end
  end

  task automatic drive_idle();
    s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 2'd2; s_writedata = '0;
    lvl_valid = 1'b0; lvl_data = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_idle();
    s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
  endtask

  task automatic sample(input logic [15:0] d);
    @(negedge clk);
    drive_idle();
    lvl_valid = 1'b1; lvl_data = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset_n = 1'b0;
    cyc(2);
    @(negedge clk);
    reset_n = 1'b1;
    wlog.delete();
    stlog.delete();
  endtask

  task automatic check_log(input string name, input bit st);
    int got[$];
    if (st) got = stlog;
    else got = wlog;
    chk({name, " count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    drive_idle();
    cyc(2);
    #2;
    chk("reset m_chipselect", 32'(m_chipselect), 32'h0);
    chk("reset m_write_n", 32'(m_write_n), 32'h1);
    chk("reset m_writedata", m_writedata, 32'h0);
    for (int a = 0; a < 4; a++) begin
      s_address = 2'(a);
      #1;
      chk($sformatf("reset csr%0d", a), s_readdata, 32'h0);
    end

    // Single mid-level sample: bar 3, then the peak marker decays away
    do_reset();
    csr_wr(2'd0, 32'h1);
    sample(16'h4000);
    cyc(40);
    exp_q = '{32'h07, 32'h04, 32'h02, 32'h01, 32'h00};
    check_log("single_sample", 0);

    // Full-scale sample then silence
    do_reset();
    csr_wr(2'd0, 32'h1);
    sample(16'hFFFF);
    cyc(90);
    exp_q = '{32'hFF, 32'h80, 32'h40, 32'h20, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01, 32'h00};
    check_log("full_scale", 0);

    // Steady level: one write, repeats suppressed
    do_reset();
    csr_wr(2'd0, 32'h1);
    repeat (30) sample(16'h2000);
    cyc(2);
    exp_q = '{32'h03};
    check_log("steady", 0);

    // Manual mode: CPU writes only, STATUS read while the write is on the bus
    do_reset();
    csr_wr(2'd3, 32'hFF);
    csr_wr(2'd1, 32'hA5);
    csr_wr(2'd0, 32'h3);
    sample(16'h4000);
    cyc(2);
    csr_wr(2'd1, 32'h3C);
    cyc(8);
    exp_q = '{32'hA5, 32'h3C};
    check_log("manual", 0);
    exp_q = '{32'h0000_0001, 32'h0000_A501};
    check_log("status_busy", 1);
    csr_wr(2'd0, 32'h1);
    cyc(20);

    // Reset in the middle of an auto write
    do_reset();
    csr_wr(2'd0, 32'h1);
    sample(16'h4000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      drive_idle();
      #2;
      found = m_chipselect;
    end
    chk("wr_auto seen", 32'(found), 32'h1);
    if (found) begin
      #1 reset_n = 1'b0;
      #1;
      chk("abort m_chipselect", 32'(m_chipselect), 32'h0);
      chk("abort m_write_n", 32'(m_write_n), 32'h1);
      chk("abort m_writedata", m_writedata, 32'h0);
      for (int a = 0; a < 4; a++) begin
        s_address = 2'(a);
        #1;
        chk($sformatf("abort csr%0d", a), s_readdata, 32'h0);
      end
    end
    cyc(2);
    @(negedge clk);
    reset_n = 1'b1;
    wlog.delete();
    cyc(20);
    exp_q.delete();
    check_log("after_abort", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
